// File: rtl/sm_pkg.sv
// sm_pkg -- shared definitions for the shift-add multiplier datapath.
//
// Contents:
//   SM_WIDTH       default operand width
//   SM_PROD_WIDTH  product width for the default operand width
//   prod_width()   product width (2*w) for any operand width w
//   rs_op_e        running-sum operation, one per control cycle
//   rs_op_sel()    priority encoder: clear beats load beats shift
package sm_pkg;

  localparam int unsigned SM_WIDTH      = 4;
  localparam int unsigned SM_PROD_WIDTH = 2 * SM_WIDTH;

  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

  typedef enum logic [1:0] {
    RS_HOLD  = 2'd0,
    RS_CLEAR = 2'd1,
    RS_LOAD  = 2'd2,
    RS_SHR   = 2'd3
  } rs_op_e;

  // Only one running-sum operation may take effect per cycle.
  function automatic rs_op_e rs_op_sel(input logic clear, input logic load,
                                       input logic shr);
    if (clear) return RS_CLEAR;
    if (load)  return RS_LOAD;
    if (shr)   return RS_SHR;
    return RS_HOLD;
  endfunction

endpackage

// File: rtl/sm_out_buf.sv
// sm_out_buf -- product capture buffer with valid/ready handshake and a
// sticky overrun flag.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   capture_i  load data_i into the buffer this edge
//   data_i     product to capture
//   ready_i    downstream accepts data_o while valid_o is high
//   data_o     captured product
//   valid_o    data_o holds an unconsumed result
//   ovr_o      sticky: a result was overwritten before it was accepted
//   cnt_o      capture counter, wraps at 16 bits (only with SM_PROD_CNT_EN)
//
// Configuration macro: SM_PROD_CNT_EN adds the capture counter and cnt_o.
module sm_out_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
`ifdef SM_PROD_CNT_EN
  output logic [15:0]   cnt_o,
`endif
  output logic          ovr_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          ovr_q;

  // A capture always wins over consumption: if the old result is being
  // accepted in the same cycle nothing is lost, so only an unaccepted
  // result being replaced raises the overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (capture_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      if (valid_q && !ready_i) ovr_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef SM_PROD_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt_q <= '0;
    else if (capture_i) cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

endmodule

// File: rtl/sm_datapath.sv
// sm_datapath -- datapath of a shift-add multiplier. The control unit drives
// the load/clear/add/shift strobes; this block holds the operands and running
// sum and hands the finished product to an output buffer.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   mdld, mrld         load multiplicand / multiplier from md_in / mr_in
//   rsclear            clear running sum
//   rsload             add multiplicand into upper half of running sum
//   rsshr              logical right shift of running sum
//   done               final-shift cycle marker from control
//   md_in, mr_in       operands, WIDTH bits
//   mr                 multiplier register, for control bit tests
//   prod, prod_valid   captured product and its valid flag
//   prod_ready         downstream accepts prod
//   ovr                sticky overrun flag
//   prod_cnt           capture count (only with SM_PROD_CNT_EN)
//
// Configuration macro: SM_PROD_CNT_EN adds the 16-bit prod_cnt output.
module sm_datapath
  import sm_pkg::*;
#(
  parameter int unsigned WIDTH = SM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mdld,
  input  logic                  mrld,
  input  logic                  rsclear,
  input  logic                  rsload,
  input  logic                  rsshr,
  input  logic                  done,
  input  logic [WIDTH-1:0]      md_in,
  input  logic [WIDTH-1:0]      mr_in,
  output logic [WIDTH-1:0]      mr,
  output logic [2*WIDTH-1:0]    prod,
  output logic                  prod_valid,
  input  logic                  prod_ready,
`ifdef SM_PROD_CNT_EN
  output logic [15:0]           prod_cnt,
`endif
  output logic                  ovr
);

  localparam int unsigned PW = prod_width(WIDTH);

  logic [WIDTH-1:0] md_q;
  logic [WIDTH-1:0] mr_q;
  logic [PW:0]      rs_q;
  logic [PW:0]      rs_d;
  logic             done_q;
  logic [WIDTH:0]   sum;

  // The add ignores the old carry bit: after every add the control shifts,
  // which moves the carry into the upper half before the next add.
  assign sum = {1'b0, rs_q[PW-1:WIDTH]} + {1'b0, md_q};

  always_comb begin
    rs_d = rs_q;
    unique case (rs_op_sel(rsclear, rsload, rsshr))
      RS_CLEAR: rs_d = '0;
      RS_LOAD:  rs_d = {sum, rs_q[WIDTH-1:0]};
      RS_SHR:   rs_d = {1'b0, rs_q[PW:1]};
      default:  rs_d = rs_q;
    endcase
  end

  // done is delayed one cycle so the capture sees the result of the final
  // shift, which happens on the same edge that done is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_q   <= '0;
      mr_q   <= '0;
      rs_q   <= '0;
      done_q <= 1'b0;
    end else begin
      if (mdld) md_q <= md_in;
      if (mrld) mr_q <= mr_in;
      rs_q   <= rs_d;
      done_q <= done;
    end
  end

  sm_out_buf #(
    .DW(PW)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (done_q),
    .data_i    (rs_q[PW-1:0]),
    .ready_i   (prod_ready),
    .data_o    (prod),
    .valid_o   (prod_valid),
`ifdef SM_PROD_CNT_EN
    .cnt_o     (prod_cnt),
`endif
    .ovr_o     (ovr)
  );

  assign mr = mr_q;

endmodule

// File: tb/tb_sm_datapath.sv
// tb_sm_datapath -- directed self-checking bench for sm_datapath (WIDTH=4).
// The bench plays the control unit: per multiplier bit it issues an add when
// the bit is set, then a shift, with done on the last shift.
// With SM_PROD_CNT_EN defined the capture counter is also exercised.
module tb_sm_datapath;

  logic       clk;
  logic       rst;
  logic       mdld, mrld, rsclear, rsload, rsshr, done;
  logic [3:0] md_in, mr_in;
  logic [3:0] mr;
  logic [7:0] prod;
  logic       prod_valid;
  logic       prod_ready;
  logic       ovr;
`ifdef SM_PROD_CNT_EN
  logic [15:0] prod_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  sm_datapath #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mdld       (mdld),
    .mrld       (mrld),
    .rsclear    (rsclear),
    .rsload     (rsload),
    .rsshr      (rsshr),
    .done       (done),
    .md_in      (md_in),
    .mr_in      (mr_in),
    .mr         (mr),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
`ifdef SM_PROD_CNT_EN
    .prod_cnt   (prod_cnt),
`endif
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven and
  // outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full control sequence. On return done_q is set; the capture edge is the
  // next tick. stress raises extra strobes that must lose on priority.
  task automatic run_mult(input logic [3:0] a, input logic [3:0] b,
                          input bit stress);
    md_in = a; mr_in = b; mdld = 1'b1; mrld = 1'b1;
    tick();
    mdld = 1'b0; mrld = 1'b0;
    rsclear = 1'b1;
    if (stress) begin rsload = 1'b1; rsshr = 1'b1; end
    tick();
    rsclear = 1'b0; rsload = 1'b0; rsshr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        rsload = 1'b1; rsshr = stress;
        tick();
        rsload = 1'b0; rsshr = 1'b0;
      end
      rsshr = 1'b1; done = (i == 3);
      tick();
      rsshr = 1'b0; done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mdld = 0; mrld = 0; rsclear = 0; rsload = 0; rsshr = 0;
    done = 0; md_in = 4'h0; mr_in = 4'h0; prod_ready = 1'b1;
    tick();
    tick();
    if ({mr, prod, prod_valid, ovr} !== 14'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=0", {mr, prod, prod_valid, ovr});
    end
    checks++;
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    prod_ready = 1'b1;
    run_mult(4'd13, 4'd11, 1'b0);
    if (prod_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_early_valid got=%b want=0", prod_valid);
    end
    checks++;
    tick();
    if (prod !== 8'h8F) begin
      failures++; $display("[TB] FAIL basic_prod got=%h want=8f", prod);
    end
    checks++;
    if (prod_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL basic_valid got=%b want=1", prod_valid);
    end
    checks++;
    tick();
    if (prod_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_valid_drop got=%b want=0", prod_valid);
    end
    checks++;
  endtask

  task automatic test_carry();
    prod_ready = 1'b1;
    run_mult(4'd15, 4'd15, 1'b0);
    if (mr !== 4'hF) begin
      failures++; $display("[TB] FAIL carry_mr got=%h want=f", mr);
    end
    checks++;
    tick();
    if (prod !== 8'hE1) begin
      failures++; $display("[TB] FAIL carry_prod got=%h want=e1", prod);
    end
    checks++;
    tick();
  endtask

  task automatic test_zero();
    logic [3:0] a [2];
    logic [3:0] b [2];
    a[0] = 4'd0; b[0] = 4'd9;
    a[1] = 4'd7; b[1] = 4'd0;
    prod_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_mult(a[k], b[k], 1'b0);
      tick();
      if (prod !== 8'h00 || prod_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL zero_%0d got prod=%h valid=%b want prod=00 valid=1",
                 k, prod, prod_valid);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_consume_capture();
    prod_ready = 1'b0;
    run_mult(4'd3, 4'd5, 1'b0);
    tick();
    if (prod !== 8'h0F || prod_valid !== 1'b1 || ovr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL consume_first got prod=%h valid=%b ovr=%b want 0f/1/0",
               prod, prod_valid, ovr);
    end
    checks++;
    run_mult(4'd6, 4'd7, 1'b0);
    prod_ready = 1'b1;
    tick();
    if (prod !== 8'h2A || prod_valid !== 1'b1 || ovr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL consume_second got prod=%h valid=%b ovr=%b want 2a/1/0",
               prod, prod_valid, ovr);
    end
    checks++;
    tick();
  endtask

  task automatic test_back_to_back();
    prod_ready = 1'b0;
    run_mult(4'd3, 4'd5, 1'b0);
    tick();
    run_mult(4'd6, 4'd7, 1'b0);
    tick();
    if (prod !== 8'h2A || prod_valid !== 1'b1 || ovr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_overrun got prod=%h valid=%b ovr=%b want 2a/1/1",
               prod, prod_valid, ovr);
    end
    checks++;
    prod_ready = 1'b1;
    tick();
    if (prod_valid !== 1'b0 || ovr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_accept got valid=%b ovr=%b want 0/1", prod_valid, ovr);
    end
    checks++;
  endtask

  task automatic test_priority();
    prod_ready = 1'b1;
    run_mult(4'd5, 4'd3, 1'b1);
    tick();
    if (prod !== 8'h0F) begin
      failures++; $display("[TB] FAIL priority_prod got=%h want=0f", prod);
    end
    checks++;
    tick();
  endtask

  task automatic test_async_reset();
    prod_ready = 1'b1;
    md_in = 4'd2; mr_in = 4'd3; mdld = 1'b1; mrld = 1'b1;
    tick();
    mdld = 1'b0; mrld = 1'b0; rsclear = 1'b1;
    tick();
    rsclear = 1'b0; rsload = 1'b1;
    tick();
    rsload = 1'b0; rsshr = 1'b1; done = 1'b1;
    tick();
    rsshr = 1'b0; done = 1'b0;
    #2 rst = 1'b0;
    #1;
    if ({mr, prod, prod_valid, ovr} !== 14'h0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%h want=0", {mr, prod, prod_valid, ovr});
    end
    checks++;
    tick();
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (prod_valid !== 1'b0 || prod !== 8'h00) begin
        failures++;
        $display("[TB] FAIL no_capture_after_reset_%0d got valid=%b prod=%h want 0/00",
                 k, prod_valid, prod);
      end
      checks++;
    end
    run_mult(4'd2, 4'd3, 1'b0);
    tick();
    if (prod !== 8'h06 || prod_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset_prod got prod=%h valid=%b want 06/1", prod, prod_valid);
    end
    checks++;
    tick();
  endtask

`ifdef SM_PROD_CNT_EN
  task automatic test_prod_cnt();
    prod_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_mult(4'd1, 4'd1, 1'b0);
      tick();
      tick();
    end
    if (prod_cnt !== 16'd3) begin
      failures++; $display("[TB] FAIL cnt_three got=%0d want=3", prod_cnt);
    end
    checks++;
    force dut.u_out_buf.cnt_q = 16'hFFFF;
    #1 release dut.u_out_buf.cnt_q;
    run_mult(4'd1, 4'd1, 1'b0);
    tick();
    if (prod_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL cnt_wrap got=%h want=0000", prod_cnt);
    end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_consume_capture();
    test_back_to_back();
    test_priority();
    test_async_reset();
`ifdef SM_PROD_CNT_EN
    test_prod_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_datapath.md
SM_DATAPATH -- requirements
Module: sm_datapath

Interface
REQ-001 Parameter: WIDTH, default 4, operand width; product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 mdld  input  1  load multiplicand register from md_in.
REQ-005 mrld  input  1  load multiplier register from mr_in.
REQ-006 rsclear  input  1  clear running-sum register.
REQ-007 rsload  input  1  add multiplicand into upper half of running sum.
REQ-008 rsshr  input  1  shift running sum right one bit.
REQ-009 done  input  1  final-shift cycle indicator from control.
REQ-010 md_in  input  WIDTH  multiplicand operand.
REQ-011 mr_in  input  WIDTH  multiplier operand.
REQ-012 mr  output  WIDTH  multiplier register contents, fed to control for bit tests.
REQ-013 prod  output  2*WIDTH  captured product.
REQ-014 prod_valid  output  1  prod holds an unconsumed result.
REQ-015 prod_ready  input  1  downstream accepts prod when prod_valid is high.
REQ-016 ovr  output  1  sticky flag: a result was overwritten before acceptance.

Function
REQ-017 Multiplicand and multiplier registers shall load on the edge where mdld/mrld is high, and shall otherwise hold.
REQ-018 Running sum rs shall be 2*WIDTH+1 bits; bit 2*WIDTH holds the adder carry.
REQ-019 rsclear: rs <= 0.
REQ-020 rsload: rs[2W:W] <= rs[2W-1:W] + md (W+1-bit result, zero-extended operands); rs[W-1:0] holds.
REQ-021 rsshr: rs <= {1'b0, rs[2W:1]} (logical right shift).
REQ-022 Priority if several rs controls are high in one cycle: rsclear > rsload > rsshr; only the winner takes effect.
REQ-023 done shall be registered into done_q; on the edge where done_q=1, prod <= rs[2W-1:0]. Capture is therefore one cycle after done, so it sees the post-shift value.
REQ-024 prod_valid shall set on capture and clear on the edge where prod_valid && prod_ready && no capture occurs.
REQ-025 Capture while prod_valid=1 and prod_ready=0: prod is overwritten, prod_valid stays 1, ovr <= 1.
REQ-026 Capture while prod_valid=1 and prod_ready=1: the old result is consumed, the new one is loaded, prod_valid stays 1, and ovr is unchanged.
REQ-027 ovr shall clear only on reset.
REQ-028 Operand loads during an active multiplication shall be obeyed without protection; sequencing is the control unit's responsibility.

Reset
REQ-029 While rst=0, all of the following shall be 0: md, mr, rs, done_q, prod, prod_valid, ovr.
REQ-030 Reset mid-operation shall abort the multiplication; no capture shall occur from a done that precedes or overlaps reset.

Configuration
REQ-031 Macro SM_PROD_CNT_EN.
- Defined: add output prod_cnt [15:0], incremented on each capture, wrapping 0xFFFF->0, reset to 0.
- Undefined: the port and its counter are absent.

Structure
REQ-032 Package sm_pkg shall hold WIDTH default, product-width function/constant 2*WIDTH, and the rs priority encoding.
REQ-033 One sub-module, sm_out_buf, shall implement the capture / valid-ready / ovr / prod_cnt logic; the arithmetic registers stay in sm_datapath.

Verification
REQ-034 WIDTH=4, md_in=13, mr_in=11, full control sequence, prod_ready=1 -> prod=0x8F and prod_valid high for one cycle, one cycle after done.
REQ-035 md_in=15, mr_in=15 -> prod=0xE1; rs carry bit exercised by rsload.
REQ-036 md_in=0, mr_in=9 and md_in=7, mr_in=0 -> prod=0x00 in both cases, with valid asserted.
REQ-037 prod_ready=0, two back-to-back multiplications 3*5 then 6*7 -> prod=0x2A, prod_valid=1, ovr=1; then prod_ready=1 -> prod_valid drops the next edge.
REQ-038 rst asserted asynchronously mid-multiplication (after one rsload) -> all outputs 0 immediately; no prod_valid afterward; the next 2*3 run gives 0x06.
REQ-039 With SM_PROD_CNT_EN defined, three accepted products -> prod_cnt=3; forced count of 0xFFFF plus one capture -> 0.
